exec_ctrl: RTL and testbench

Execution controller for the single-cycle RV32I core. It sits between the host/debug side and the processor and produces a per-cycle commit enable (`proc_en`) that gates PC update, register-file write and `MemWrite`. It halts the core on `Ecall`, `Ebreak`, a PC breakpoint or a host command. From the halted state it supports run and N-instruction single-step, and it keeps cycle and retired-instruction counters.

---
 rtl/exec_ctrl_pkg.sv | 38 +++
 rtl/exec_counter.sv | 21 ++
 rtl/exec_ctrl.sv | 130 +++++++++++++
 tb/tb_exec_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/exec_ctrl_pkg.sv
// exec_ctrl_pkg: shared encodings for the execution controller.
//   cmd_op_e     - host command opcodes (cmd_op port)
//   halt_cause_e - halt reason reported on halt_cause
//   state_e      - controller FSM states
//   event_cause  - priority encoder for in-flight halt events
package exec_ctrl_pkg;

  typedef enum logic [1:0] {
    CMD_RUN     = 2'd0,
    CMD_HALT    = 2'd1,
    CMD_STEP    = 2'd2,
    CMD_CLR_CNT = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    CAUSE_NONE       = 3'd0,
    CAUSE_RESET      = 3'd1,
    CAUSE_HOST       = 3'd2,
    CAUSE_STEP_DONE  = 3'd3,
    CAUSE_BREAKPOINT = 3'd4,
    CAUSE_ECALL      = 3'd5,
    CAUSE_EBREAK     = 3'd6
  } halt_cause_e;

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2
  } state_e;

  // EBREAK outranks ECALL, which outranks a PC breakpoint.
  function automatic halt_cause_e event_cause(input logic ebreak, input logic ecall);
    if (ebreak)     return CAUSE_EBREAK;
    else if (ecall) return CAUSE_ECALL;
    else            return CAUSE_BREAKPOINT;
  endfunction

endpackage

// File: rtl/exec_counter.sv
// exec_counter: W-bit wrapping counter.
//   clk, rst - clock, synchronous active-high reset (clears count)
//   inc      - add one this cycle
//   clr      - zero the count next cycle; wins over inc
//   cnt      - current count
module exec_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (inc)   cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/exec_ctrl.sv
// exec_ctrl: execution controller for the single-cycle RV32I core.
// Produces the per-cycle commit enable, halts on ECALL/EBREAK/PC breakpoint
// or host command, supports run and N-instruction step from halt, and keeps
// cycle and retired-instruction counters.
//   clk, rst              - clock, synchronous active-high reset
//   Ecall, Ebreak, pc     - decode of the current instruction and its PC
//   bp_en, bp_addr        - PC breakpoint
//   cmd_valid/op/arg      - host command, accepted when cmd_valid && cmd_ready
//   cmd_ready             - command can be accepted this cycle
//   proc_en               - current instruction commits this cycle
//   halted, halt_cause    - registered halt status and reason
//   halt_pc               - PC of first uncommitted instruction at halt
//   cycle_cnt, instret    - wrapping cycle / retired-instruction counters
module exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned STEP_W   = 16,
  parameter bit          BOOT_RUN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Ecall,
  input  logic              Ebreak,
  input  logic [31:0]       pc,
  input  logic              bp_en,
  input  logic [31:0]       bp_addr,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_arg,
  output logic              cmd_ready,
  output logic              proc_en,
  output logic              halted,
  output logic [2:0]        halt_cause,
  output logic [31:0]       halt_pc,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instret
);

  state_e            state;
  halt_cause_e       cause_q;
  logic              skip;
  logic [STEP_W-1:0] step_cnt;

  cmd_op_e op;
  logic    running;
  logic    trig;
  logic    ev;
  logic    cmd_acc;
  logic    step_last;
  logic    clr_cnt;

  assign op      = cmd_op_e'(cmd_op);
  assign running = (state != ST_HALTED);
  assign trig    = Ebreak || Ecall || (bp_en && (pc == bp_addr));
  // skip masks the event for the first cycle after resuming, so the
  // instruction that caused the previous halt commits exactly once.
  assign ev      = running && !skip && trig;
  assign proc_en = !rst && running && !ev;

  assign cmd_ready = !rst && ((state == ST_HALTED) || (op == CMD_HALT) || (op == CMD_CLR_CNT));
  assign cmd_acc   = cmd_valid && cmd_ready;
  assign clr_cnt   = cmd_acc && (op == CMD_CLR_CNT);
  assign step_last = (state == ST_STEP) && (step_cnt == STEP_W'(1));

  assign halt_cause = cause_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT_RUN ? ST_RUN : ST_HALTED;
      halted   <= !BOOT_RUN;
      cause_q  <= BOOT_RUN ? CAUSE_NONE : CAUSE_RESET;
      halt_pc  <= '0;
      step_cnt <= '0;
      skip     <= 1'b0;
    end else if (state == ST_HALTED) begin
      // HALT and CLR_CNT while halted leave the FSM untouched.
      if (cmd_acc && (op == CMD_RUN)) begin
        state   <= ST_RUN;
        halted  <= 1'b0;
        cause_q <= CAUSE_NONE;
        skip    <= 1'b1;
      end else if (cmd_acc && (op == CMD_STEP)) begin
        state    <= ST_STEP;
        halted   <= 1'b0;
        cause_q  <= CAUSE_NONE;
        skip     <= 1'b1;
        step_cnt <= (cmd_arg == '0) ? STEP_W'(1) : cmd_arg;
      end
    end else begin
      skip <= 1'b0;
      // Priority: event > step done > host halt.
      if (ev) begin
        state   <= ST_HALTED;
        halted  <= 1'b1;
        cause_q <= event_cause(Ebreak, Ecall);
        halt_pc <= pc;
      end else if (proc_en && step_last) begin
        state   <= ST_HALTED;
        halted  <= 1'b1;
        cause_q <= CAUSE_STEP_DONE;
        halt_pc <= pc + 32'd4;
      end else if (cmd_acc && (op == CMD_HALT)) begin
        state   <= ST_HALTED;
        halted  <= 1'b1;
        cause_q <= CAUSE_HOST;
        halt_pc <= proc_en ? (pc + 32'd4) : pc;
      end else if ((state == ST_STEP) && proc_en) begin
        step_cnt <= step_cnt - STEP_W'(1);
      end
    end
  end

  exec_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .inc (1'b1),
    .clr (clr_cnt),
    .cnt (cycle_cnt)
  );

  exec_counter #(.W(CNT_W)) u_instret (
    .clk (clk),
    .rst (rst),
    .inc (proc_en),
    .clr (clr_cnt),
    .cnt (instret)
  );

endmodule

// File: tb/tb_exec_ctrl.sv
// tb_exec_ctrl: directed scenarios followed by randomized stimulus, every
// cycle compared against a behavioural model of the controller.
module tb_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst, Ecall, Ebreak, bp_en, cmd_valid;
  logic [31:0] pc, bp_addr;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_arg;
  logic        cmd_ready, proc_en, halted;
  logic [2:0]  halt_cause;
  logic [31:0] halt_pc, cycle_cnt, instret;

  always #5 clk = ~clk;

  exec_ctrl #(.CNT_W(32), .STEP_W(16), .BOOT_RUN(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .Ecall      (Ecall),
    .Ebreak     (Ebreak),
    .pc         (pc),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .cmd_ready  (cmd_ready),
    .proc_en    (proc_en),
    .halted     (halted),
    .halt_cause (halt_cause),
    .halt_pc    (halt_pc),
    .cycle_cnt  (cycle_cnt),
    .instret    (instret)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural model: "halted / stepping with N left / just resumed".
  bit          m_halted   = 1'b0;
  bit          m_stepping = 1'b0;
  bit          m_resumed  = 1'b0;
  int          m_left     = 0;
  int          m_cause    = 0;
  logic [31:0] m_hpc      = '0;
  logic [31:0] m_cyc      = '0;
  logic [31:0] m_ret      = '0;
  bit          e_evt, e_pen, e_rdy;
  logic        last_pen, last_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_halt(input int cause, input logic [31:0] at);
    m_halted   = 1'b1;
    m_stepping = 1'b0;
    m_cause    = cause;
    m_hpc      = at;
  endtask

  task automatic model_edge();
    bit acc;
    acc = cmd_valid && e_rdy;
    if (rst) begin
      m_halted = 1'b0; m_stepping = 1'b0; m_resumed = 1'b0; m_left = 0;
      m_cause = 0; m_hpc = '0; m_cyc = '0; m_ret = '0;
      return;
    end
    if (acc && cmd_op == 2'd3) begin
      m_cyc = '0;
      m_ret = '0;
    end else begin
      m_cyc = m_cyc + 1;
      m_ret = m_ret + (e_pen ? 1 : 0);
    end
    if (m_halted) begin
      if (acc && cmd_op == 2'd0) begin
        m_halted = 1'b0; m_stepping = 1'b0; m_resumed = 1'b1; m_cause = 0;
      end else if (acc && cmd_op == 2'd2) begin
        m_halted = 1'b0; m_stepping = 1'b1; m_resumed = 1'b1; m_cause = 0;
        m_left = (cmd_arg == 0) ? 1 : int'(cmd_arg);
      end
    end else begin
      m_resumed = 1'b0;
      if (e_evt)                        model_halt(Ebreak ? 6 : (Ecall ? 5 : 4), pc);
      else if (m_stepping && m_left == 1) model_halt(3, pc + 32'd4);
      else if (acc && cmd_op == 2'd1)   model_halt(2, pc + 32'd4);
      else if (m_stepping)              m_left--;
    end
  endtask

  // One clock: check combinational outputs mid-cycle, advance the model at
  // the edge, then check registered outputs just after it.
  task automatic tick();
    @(negedge clk);
    e_evt = !m_halted && !m_resumed && (Ebreak || Ecall || (bp_en && pc == bp_addr));
    e_pen = !rst && !m_halted && !e_evt;
    e_rdy = !rst && (m_halted || cmd_op == 2'd1 || cmd_op == 2'd3);
    last_pen = proc_en;
    last_rdy = cmd_ready;
    chk("proc_en", proc_en, e_pen);
    chk("cmd_ready", cmd_ready, e_rdy);
    @(posedge clk);
    model_edge();
    #1;
    chk("halted", halted, m_halted);
    chk("cycle_cnt", cycle_cnt, m_cyc);
    chk("instret", instret, m_ret);
    chk("halt_pc", halt_pc, m_hpc);
    if (m_halted) chk("halt_cause", halt_cause, m_cause);
  endtask

  task automatic cmd(input logic [1:0] op, input logic [15:0] arg);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    int n;
    rst = 1'b1; Ecall = 1'b0; Ebreak = 1'b0; bp_en = 1'b0; bp_addr = '0;
    pc = '0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = '0;

    // Boot run
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin pc = 32'(i * 4); tick(); end
    chk("boot_instret", instret, 32'd10);
    chk("boot_cycle", cycle_cnt, 32'd10);
    chk("boot_halted", halted, 1'b0);

    // Ebreak halt, then resume commits it once
    pc = 32'h40; Ebreak = 1'b1;
    tick();
    chk("ebreak_pen", last_pen, 1'b0);
    chk("ebreak_halted", halted, 1'b1);
    chk("ebreak_cause", halt_cause, 3'd6);
    chk("ebreak_pc", halt_pc, 32'h40);
    cmd(2'd0, 16'd0);
    tick();
    chk("resume_commit", last_pen, 1'b1);
    chk("resume_no_rehalt", halted, 1'b0);
    Ebreak = 1'b0; pc = 32'h44;
    tick();

    // Breakpoint
    bp_en = 1'b1; bp_addr = 32'h1C;
    pc = 32'h14; tick();
    pc = 32'h18; tick();
    pc = 32'h1C; r = instret;
    tick();
    chk("bp_pen", last_pen, 1'b0);
    chk("bp_cause", halt_cause, 3'd4);
    chk("bp_pc", halt_pc, 32'h1C);
    chk("bp_instret", instret, r);
    bp_en = 1'b0;

    // Step 3, then step 0
    for (int s = 0; s < 2; s++) begin
      pc = 32'h8;
      cmd(2'd2, (s == 0) ? 16'd3 : 16'd0);
      r = instret; n = 0;
      for (int k = 0; k < 20 && !halted; k++) begin
        tick();
        n += last_pen ? 1 : 0;
        pc = pc + 32'd4;
      end
      chk("step_halted", halted, 1'b1);
      chk("step_commits", n, (s == 0) ? 3 : 1);
      chk("step_cause", halt_cause, 3'd3);
      chk("step_instret", instret, r + ((s == 0) ? 32'd3 : 32'd1));
    end

    // Simultaneous HALT + Ecall, and RUN while running
    cmd(2'd0, 16'd0);
    pc = 32'h70; tick();
    cmd_valid = 1'b1; cmd_op = 2'd0; tick(); cmd_valid = 1'b0;
    chk("run_while_running_rdy", last_rdy, 1'b0);
    pc = 32'h80; Ecall = 1'b1;
    cmd(2'd1, 16'd0);
    Ecall = 1'b0;
    chk("simul_cause", halt_cause, 3'd5);
    chk("simul_pc", halt_pc, 32'h80);

    // Clear counters while running
    cmd(2'd0, 16'd0);
    tick();
    cmd(2'd3, 16'd0);
    chk("clr_cycle", cycle_cnt, 32'd0);
    chk("clr_instret", instret, 32'd0);
    tick();
    chk("clr_cycle_1", cycle_cnt, 32'd1);
    chk("clr_instret_1", instret, 32'd1);

    // Reset mid-step
    cmd(2'd1, 16'd0);
    cmd(2'd2, 16'd5);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("rst_pen", last_pen, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_cycle", cycle_cnt, 32'd0);
    chk("rst_instret", instret, 32'd0);
    rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      rst       = ($urandom_range(0, 99) < 2);
      Ecall     = ($urandom_range(0, 99) < 6);
      Ebreak    = ($urandom_range(0, 99) < 5);
      bp_en     = ($urandom_range(0, 99) < 25);
      pc        = 32'($urandom_range(0, 15)) * 32'd4;
      bp_addr   = ($urandom_range(0, 1) == 1) ? pc : 32'($urandom_range(0, 15)) * 32'd4;
      cmd_valid = ($urandom_range(0, 99) < 35);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_arg   = 16'($urandom_range(0, 4));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
